// File: rtl/fir_mac_sequencer.sv
// Serial multiply-accumulate sequencer for the FIR filter.
// Walks the coefficient LUT one tap per cycle against the sample delay line.
// Produces one full-precision filter output per accepted input sample.
module fir_mac_sequencer #(
  parameter int LUT_size    = 64,
  parameter int data_width  = 16,
  parameter int input_width = 16,
  localparam int adr_w      = $clog2(LUT_size),
  localparam int acc_w      = input_width + data_width + $clog2(LUT_size)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          input_valid,
  input  logic signed [input_width-1:0] input_data,
  output logic                          input_ready,
  output logic        [adr_w-1:0]       coef_adr,
  input  logic signed [data_width-1:0]  coef_data,
  output logic                          output_valid,
  output logic signed [acc_w-1:0]       output_data
);

  localparam int prod_w = data_width + input_width;
  localparam logic [adr_w-1:0] cnt_last = adr_w'(LUT_size - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Sign-extend a full-precision product to accumulator width.
  function automatic logic signed [acc_w-1:0] sext_prod(input logic signed [prod_w-1:0] p);
    return {{(acc_w - prod_w){p[prod_w-1]}}, p};
  endfunction

  state_t                         state_q, state_d;
  logic        [adr_w-1:0]        cnt_q, cnt_d;
  logic signed [acc_w-1:0]        acc_q, acc_d;
  logic signed [input_width-1:0]  x_buf_q [LUT_size];
  logic signed [input_width-1:0]  x_buf_d [LUT_size];
  logic                           out_vld_q, out_vld_d;
  logic signed [acc_w-1:0]        out_data_q, out_data_d;
  logic signed [prod_w-1:0]       prod;
  logic signed [acc_w-1:0]        acc_sum;

  // Product for the current tap and the running sum it would produce.
  always_comb begin
    prod    = coef_data * x_buf_q[cnt_q];
    acc_sum = acc_q + sext_prod(prod);
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    x_buf_d     = x_buf_q;
    out_vld_d   = 1'b0;
    out_data_d  = out_data_q;
    input_ready = 1'b0;
    coef_adr    = '0;
    unique case (state_q)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          // Oldest sample sits at index 0, newest at LUT_size-1.
          for (int k = 0; k < LUT_size - 1; k++) begin
            x_buf_d[k] = x_buf_q[k+1];
          end
          x_buf_d[LUT_size-1] = input_data;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        coef_adr = cnt_q;
        acc_d    = acc_sum;
        cnt_d    = cnt_q + adr_w'(1);
        if (cnt_q == cnt_last) begin
          // Final tap: publish the complete sum including this product.
          out_data_d = acc_sum;
          out_vld_d  = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, accumulator, delay line and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      x_buf_q    <= '{default: '0};
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      x_buf_q    <= x_buf_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign output_valid = out_vld_q;
  assign output_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with a 4-tap LUT model.
module tb_fir_mac_sequencer;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int IW   = 16;
  localparam int AW   = 2;
  localparam int ACCW = 34;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  input_valid;
  logic signed [IW-1:0]  input_data;
  logic                  input_ready;
  logic        [AW-1:0]  coef_adr;
  logic signed [DW-1:0]  coef_data;
  logic                  output_valid;
  logic signed [ACCW-1:0] output_data;

  logic signed [DW-1:0]  lut [N];
  longint                xh [N];
  longint                sb [$];
  int                    acc_cyc [$];
  int                    n_tests = 0;
  int                    n_fail  = 0;
  int                    cyc     = 0;
  int                    vld_cnt = 0;
  logic                  vld_prev = 1'b0;

  assign coef_data = lut[coef_adr];

  fir_mac_sequencer #(
    .LUT_size   (N),
    .data_width (DW),
    .input_width(IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_data  (input_data),
    .input_ready (input_ready),
    .coef_adr    (coef_adr),
    .coef_data   (coef_data),
    .output_valid(output_valid),
    .output_data (output_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Direct-form reference: y = sum h[j]*x[n-j], with h[j] = LUT word N-1-j.
  function automatic longint model_y();
    longint y = 0;
    for (int j = 0; j < N; j++) y += longint'(lut[N-1-j]) * xh[j];
    return y;
  endfunction

  task automatic model_accept(input longint s);
    for (int j = N - 1; j > 0; j--) xh[j] = xh[j-1];
    xh[0] = s;
    sb.push_back(model_y());
    acc_cyc.push_back(cyc);
  endtask

  task automatic model_clear();
    for (int j = 0; j < N; j++) xh[j] = 0;
    sb.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input longint s, input bit hold);
    int n = 0;
    input_valid = 1'b1;
    input_data  = IW'(s);
    while (input_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
      input_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_accept(s);
    if (!hold) input_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    input_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each output_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (output_valid) begin
        vld_cnt++;
        chk("vld_width", vld_prev, 0);
        if (sb.size() == 0) chk("unexp_vld", output_valid, 0);
        else chk("out_data", output_data, sb.pop_front());
      end
      vld_prev = output_valid;
    end else begin
      vld_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int n;
    rst         = 1'b1;
    input_valid = 1'b0;
    input_data  = '0;
    lut         = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
    model_clear();

    @(negedge clk);
    chk("rst_vld",  output_valid, 0);
    chk("rst_data", output_data, 0);
    chk("rst_adr",  coef_adr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy", input_ready, 1);
    chk("rel_adr", coef_adr, 0);
    chk("rel_vld", output_valid, 0);

    // Impulse response
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    wait_drain();
    chk("imp_last", output_data, 4);

    // Handshake timing with input_valid held high
    v0 = vld_cnt;
    send(7, 1);
    for (int i = 0; i < N; i++) begin
      chk("tm_adr", coef_adr, i);
      chk("tm_rdy", input_ready, 0);
      chk("tm_vld", output_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("tm_vld_hi", output_valid, 1);
    chk("tm_rdy_hi", input_ready, 1);
    send(7, 0);
    wait_drain();
    chk("tm_pulses", vld_cnt - v0, 2);

    // Step, back-to-back
    do_reset();
    for (int i = 0; i < 5; i++) send(1, 1);
    input_valid = 1'b0;
    for (int i = 1; i < 5; i++) chk("step_gap", acc_cyc[i] - acc_cyc[i-1], 5);
    wait_drain();
    chk("step_last", output_data, 10);

    // Reset asserted mid-computation
    send(3, 0);
    n = 0;
    while (coef_adr !== 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", coef_adr, 2);
    v0 = vld_cnt;
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("abort_vld",  output_valid, 0);
    chk("abort_adr",  coef_adr, 0);
    chk("abort_data", output_data, 0);
    chk("abort_rdy",  input_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_vld", vld_cnt, v0);
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    wait_drain();
    chk("abort_imp_last", output_data, 4);

    // Signed extremes
    lut = '{default: 16'sh8000};
    do_reset();
    for (int i = 0; i < 4; i++) send(-32768, 0);
    wait_drain();
    chk("ext_final", output_data, 64'sd4294967296);
    do_reset();
    send(32767, 0);
    wait_drain();
    chk("ext_neg", output_data, -64'sd1073709056);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
